// File: rtl/tile_raster.sv
// -----------------------------------------------------------------------------
// tile_raster
//
// Purpose
//   Tile-map raster for the VGA path. It converts the beam counters hcnt/vcnt
//   into packed pixel words for a COLS x ROWS game board plus a floor strip
//   directly below the board.
//   The board is taken from a frame-synchronous snapshot of 'tiles'. A
//   snapshot is only loaded on an upd_req seen at frame start. This means
//   game-logic writes never tear the displayed frame.
//   The raster is a 3-stage registered pipeline, hcnt/vcnt -> pixels:
//     S1: tile coordinates
//     S2: glyph select and region flags
//     S3: colour expansion
//   It produces one word per clock and never stalls.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   hcnt        in   [0:10] horizontal beam counter
//   vcnt        in   [0:9]  vertical beam counter
//   tiles       in   live board; tile (r,c) at [(r*COLS+c)*GLYPH_W +: GLYPH_W]
//   upd_req     in   take a snapshot of tiles at the next frame start
//   upd_ack     out  one-cycle pulse, snapshot was loaded
//   pixels      out  pixel word, [0 +: PIX_BITS] is the leftmost pixel
//   pixels_vld  out  word lies in the board or floor region
//
// Configuration
//   TILE_RASTER_GRID_EN  when defined, board words get a grid gutter:
//                        - the leftmost pixel of each board word is black;
//                        - the last line of each tile row is fully black.
//                        The floor and pixels_vld are not affected.
// -----------------------------------------------------------------------------
module tile_raster #(
  parameter int COLS        = 10,
  parameter int ROWS        = 20,
  parameter int GLYPH_W     = 8,
  parameter int PIX_BITS    = 3,
  parameter int PIX_PER_W   = 16,
  parameter int TX_SHIFT    = 5,
  parameter int TY_SHIFT    = 4,
  parameter int XOFFSET     = 218,
  parameter int YOFFSET     = 12,
  parameter int BOARD_X0    = 14,
  parameter int BOARD_Y0    = 8,
  parameter int FLOOR_COLOR = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [0:10]                         hcnt,
  input  logic [0:9]                          vcnt,
  input  logic [0:COLS*ROWS*GLYPH_W-1]        tiles,
  input  logic                                upd_req,
  output logic                                upd_ack,
  output logic [0:PIX_PER_W*PIX_BITS-1]       pixels,
  output logic                                pixels_vld
);

  localparam int TXW   = 11 - TX_SHIFT;
  localparam int TYW   = 10 - TY_SHIFT;
  localparam int NBITS = COLS * ROWS * GLYPH_W;
  localparam int BASEW = $clog2(NBITS) + 1;
  localparam int PW    = PIX_PER_W * PIX_BITS;

  localparam logic [10:0]          XOFF_C   = 11'(XOFFSET);
  localparam logic [9:0]           YOFF_C   = 10'(YOFFSET);
  localparam logic [TXW-1:0]       BX0_C    = TXW'(BOARD_X0);
  localparam logic [TXW-1:0]       BX1_C    = TXW'(BOARD_X0 + COLS);
  localparam logic [TYW-1:0]       BY0_C    = TYW'(BOARD_Y0);
  localparam logic [TYW-1:0]       BY1_C    = TYW'(BOARD_Y0 + ROWS);
  localparam logic [BASEW-1:0]     COLS_C   = BASEW'(COLS);
  localparam logic [BASEW-1:0]     GLYPH_C  = BASEW'(GLYPH_W);
  localparam logic [PIX_BITS-1:0]  FLOOR_C  = PIX_BITS'(FLOOR_COLOR);
  localparam logic [TY_SHIFT-1:0]  LINE2_C  = TY_SHIFT'(32'd2);
  localparam logic [TY_SHIFT-1:0]  LINE3_C  = TY_SHIFT'(32'd3);
`ifdef TILE_RASTER_GRID_EN
  localparam logic [TY_SHIFT-1:0]  LINEL_C  = {TY_SHIFT{1'b1}};
`endif

  // ---------------------------------------------------------------------------
  // Beam offsets. The subtraction wraps on underflow, which lands far off-board.
  // ---------------------------------------------------------------------------
  logic [10:0] ox_s;
  logic [9:0]  oy_s;
  logic        frame_start_s;

  assign ox_s          = hcnt - XOFF_C;
  assign oy_s          = vcnt - YOFF_C;
  assign frame_start_s = (hcnt == 11'd0) && (vcnt == 10'd0);

  // ---------------------------------------------------------------------------
  // Board snapshot.
  // ---------------------------------------------------------------------------
  logic [0:NBITS-1] snap_r;
  logic             ack_r;

  // Snapshot register and acknowledge pulse: load only on a request at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_r <= '0;
      ack_r  <= 1'b0;
    end else if (frame_start_s && upd_req) begin
      snap_r <= tiles;
      ack_r  <= 1'b1;
    end else begin
      ack_r  <= 1'b0;
    end
  end

  assign upd_ack = ack_r;

  // ---------------------------------------------------------------------------
  // S1: tile coordinates and line within the tile.
  // ---------------------------------------------------------------------------
  logic [TXW-1:0]      s1_tx_r;
  logic [TYW-1:0]      s1_ty_r;
  logic [TY_SHIFT-1:0] s1_line_r;

  // S1 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_tx_r   <= '0;
      s1_ty_r   <= '0;
      s1_line_r <= '0;
    end else begin
      s1_tx_r   <= ox_s[10:TX_SHIFT];
      s1_ty_r   <= oy_s[9:TY_SHIFT];
      s1_line_r <= oy_s[TY_SHIFT-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // S2: region classification and glyph fetch from the snapshot.
  // ---------------------------------------------------------------------------
  logic                 in_cols_s;
  logic                 in_board_s;
  logic                 in_floor_s;
  logic [TXW-1:0]       col_s;
  logic [TYW-1:0]       row_s;
  logic [BASEW-1:0]     base_s;
  logic [0:GLYPH_W-1]   glyph_s;
  logic [PIX_BITS-1:0]  color_s;

  assign in_cols_s  = (s1_tx_r >= BX0_C) && (s1_tx_r < BX1_C);
  assign in_board_s = in_cols_s && (s1_ty_r >= BY0_C) && (s1_ty_r < BY1_C);
  assign in_floor_s = in_cols_s && (s1_ty_r == BY1_C);

  // Glyph bit offset. It is forced to 0 off-board so the part-select stays in range.
  always_comb begin
    col_s  = s1_tx_r - BX0_C;
    row_s  = s1_ty_r - BY0_C;
    base_s = '0;
    if (in_board_s) begin
      base_s = ((BASEW'(row_s) * COLS_C) + BASEW'(col_s)) * GLYPH_C;
    end else begin
      base_s = '0;
    end
  end

  assign glyph_s = snap_r[base_s +: GLYPH_W];
  // The colour is the numerically low PIX_BITS of the tile code.
  assign color_s = glyph_s[GLYPH_W-PIX_BITS +: PIX_BITS];

  logic [PIX_BITS-1:0]  s2_color_r;
  logic                 s2_board_r;
  logic                 s2_floor_r;
  logic [TY_SHIFT-1:0]  s2_line_r;

  // S2 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_color_r <= '0;
      s2_board_r <= 1'b0;
      s2_floor_r <= 1'b0;
      s2_line_r  <= '0;
    end else begin
      s2_color_r <= color_s;
      s2_board_r <= in_board_s;
      s2_floor_r <= in_floor_s;
      s2_line_r  <= s1_line_r;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: expand the colour to a pixel word.
  // ---------------------------------------------------------------------------
  logic [0:PW-1] word_s;
  logic          vld_s;

  // Pixel word and valid flag for the classified region.
  always_comb begin
    word_s = '0;
    vld_s  = 1'b0;
    if (s2_board_r) begin
      vld_s  = 1'b1;
      word_s = {PIX_PER_W{s2_color_r}};
`ifdef TILE_RASTER_GRID_EN
      if (s2_line_r == LINEL_C) begin
        word_s = '0;
      end else begin
        word_s[0 +: PIX_BITS] = '0;
      end
`endif
    end else if (s2_floor_r) begin
      vld_s = 1'b1;
      if ((s2_line_r == LINE2_C) || (s2_line_r == LINE3_C)) begin
        word_s = {PIX_PER_W{FLOOR_C}};
      end else begin
        word_s = '0;
      end
    end else begin
      word_s = '0;
      vld_s  = 1'b0;
    end
  end

  logic [0:PW-1] pix_r;
  logic          vld_r;

  // S3 output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_r <= '0;
      vld_r <= 1'b0;
    end else begin
      pix_r <= word_s;
      vld_r <= vld_s;
    end
  end

  assign pixels     = pix_r;
  assign pixels_vld = vld_r;

endmodule

// File: tb/tb_tile_raster.sv
// -----------------------------------------------------------------------------
// tb_tile_raster
//
// Self-checking bench for tile_raster with its default parameters.
// Each step drives hcnt/vcnt/upd_req on the falling edge. It also pushes the
// expected pixel word and valid flag into a scoreboard queue. Three steps
// later the entry is popped and compared with the DUT outputs.
// upd_ack is checked every step against the previous step's request.
// -----------------------------------------------------------------------------
module tb_tile_raster;

  localparam int PW = 48;

  typedef struct {
    int              id;
    bit              cp;
    bit              cv;
    logic [0:PW-1]   pix;
    logic            vld;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [0:10]     hcnt;
  logic [0:9]      vcnt;
  logic [0:1599]   tiles;
  logic            upd_req;
  logic            upd_ack;
  logic [0:PW-1]   pixels;
  logic            pixels_vld;

  exp_t q[$];
  int   checks;
  int   errors;
  int   step_id;
  logic exp_ack;

  tile_raster dut (
    .clk        (clk),
    .rst        (rst),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .tiles      (tiles),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .pixels     (pixels),
    .pixels_vld (pixels_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_tile(input int r, input int c, input logic [7:0] code);
    tiles[(r*10+c)*8 +: 8] = code;
  endtask

  // One beam position per clock.
  // cp/cv select whether the pixel word and the valid flag are checked.
  task automatic step(input int h, input int v, input bit req,
                      input bit cp, input bit cv,
                      input logic [0:PW-1] ep, input logic ev);
    exp_t e;
    @(negedge clk);
    if (q.size() == 3) begin
      e = q.pop_front();
      if (e.cp) begin
        checks++;
        assert (pixels === e.pix)
        else begin
          errors++;
          $error("FAIL pixels step=%0d got=%h exp=%h", e.id, pixels, e.pix);
        end
      end
      if (e.cv) begin
        checks++;
        assert (pixels_vld === e.vld)
        else begin
          errors++;
          $error("FAIL pixels_vld step=%0d got=%b exp=%b", e.id, pixels_vld, e.vld);
        end
      end
    end
    checks++;
    assert (upd_ack === exp_ack)
    else begin
      errors++;
      $error("FAIL upd_ack step=%0d got=%b exp=%b", step_id, upd_ack, exp_ack);
    end
    exp_ack = (h == 0) && (v == 0) && req;
    hcnt    = 11'(h);
    vcnt    = 10'(v);
    upd_req = req;
    e.id  = step_id;
    e.cp  = cp;
    e.cv  = cv;
    e.pix = ep;
    e.vld = ev;
    q.push_back(e);
    step_id++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_ack = 1'b0;
    checks++;
    assert ((pixels === 48'd0) && (pixels_vld === 1'b0) && (upd_ack === 1'b0))
    else begin
      errors++;
      $error("FAIL reset_state got=%h/%b/%b exp=0/0/0", pixels, pixels_vld, upd_ack);
    end
  endtask

  initial begin
    logic [0:PW-1] c5;
    logic [0:PW-1] c2;
    logic [0:PW-1] c7;
    logic [0:PW-1] c1;
    logic [0:PW-1] c4;
    logic [0:PW-1] c3;
    logic [0:PW-1] z;
    checks  = 0;
    errors  = 0;
    step_id = 0;
    exp_ack = 1'b0;
    hcnt    = '0;
    vcnt    = '0;
    upd_req = 1'b0;
    tiles   = '0;
    rst     = 1'b1;
    z  = '0;
    c3 = {16{3'd3}};
`ifdef TILE_RASTER_GRID_EN
    c5 = {3'd0, {15{3'b101}}};
    c2 = {3'd0, {15{3'b010}}};
    c7 = {3'd0, {15{3'b111}}};
    c1 = {3'd0, {15{3'b001}}};
    c4 = {3'd0, {15{3'b100}}};
`else
    c5 = {16{3'b101}};
    c2 = {16{3'b010}};
    c7 = {16{3'b111}};
    c1 = {16{3'b001}};
    c4 = {16{3'b100}};
`endif

    // Reset, then sweep before any update. The display must stay black.
    do_reset();
    set_tile(0, 0, 8'h05);
    step(0,   0,   1'b0, 1'b1, 1'b1, z, 1'b0);   // frame start without request
    step(666, 140, 1'b0, 1'b1, 1'b0, z, 1'b0);   // board, snapshot still empty
    step(300, 50,  1'b0, 1'b1, 1'b1, z, 1'b0);
    step(986, 140, 1'b0, 1'b1, 1'b1, z, 1'b0);
    step(700, 462, 1'b0, 1'b1, 1'b1, c3, 1'b1);  // floor is drawn without a snapshot

    // First update, then the tile (0,0) pixel.
    set_tile(0, 9, 8'hFF);
    set_tile(19, 9, 8'h0C);
    set_tile(19, 0, 8'hF9);
    step(0,   0,   1'b1, 1'b1, 1'b1, z, 1'b0);
    step(666, 140, 1'b0, 1'b1, 1'b1, c5, 1'b1);
    step(954, 140, 1'b0, 1'b1, 1'b1, c7, 1'b1);  // last column
    step(954, 444, 1'b0, 1'b1, 1'b1, c4, 1'b1);  // bottom-right tile
    step(666, 444, 1'b0, 1'b1, 1'b1, c1, 1'b1);  // high code bits ignored
    step(690, 300, 1'b0, 1'b1, 1'b1, z,  1'b1);  // empty tile inside board

    // Floor and boundaries.
    step(666, 462, 1'b0, 1'b1, 1'b1, c3, 1'b1);
    step(666, 463, 1'b0, 1'b1, 1'b1, c3, 1'b1);
    step(666, 464, 1'b0, 1'b1, 1'b1, z,  1'b1);
    step(666, 476, 1'b0, 1'b1, 1'b1, z,  1'b0);  // row below the floor
    step(986, 140, 1'b0, 1'b1, 1'b1, z,  1'b0);  // column right of the board
    step(100, 140, 1'b0, 1'b1, 1'b1, z,  1'b0);  // hcnt underflow
    step(665, 140, 1'b0, 1'b1, 1'b1, z,  1'b0);  // one clock left of the board
`ifdef TILE_RASTER_GRID_EN
    step(666, 155, 1'b0, 1'b1, 1'b1, z,  1'b1);  // gutter line
`else
    step(666, 155, 1'b0, 1'b1, 1'b1, c5, 1'b1);
`endif

    // Mid-frame change without a request is not shown.
    set_tile(0, 0, 8'h02);
    step(666, 140, 1'b0, 1'b1, 1'b1, c5, 1'b1);
    step(0,   0,   1'b0, 1'b1, 1'b1, z,  1'b0);  // next frame, no request
    step(666, 140, 1'b0, 1'b1, 1'b1, c5, 1'b1);
    // A load in the same cycle as the S2 read must still give the old colour.
    step(0,   0,   1'b1, 1'b1, 1'b1, z,  1'b0);
    step(666, 140, 1'b0, 1'b1, 1'b1, c2, 1'b1);
    // With upd_req held high, there is one ack per frame start only.
    step(1,   0,   1'b1, 1'b1, 1'b1, z,  1'b0);
    step(0,   0,   1'b1, 1'b1, 1'b1, z,  1'b0);
    step(666, 140, 1'b0, 1'b1, 1'b1, c2, 1'b1);
    step(1,   1,   1'b0, 1'b0, 1'b0, z,  1'b0);
    step(1,   1,   1'b0, 1'b0, 1'b0, z,  1'b0);
    step(1,   1,   1'b0, 1'b0, 1'b0, z,  1'b0);

    // Reset mid-frame clears the snapshot.
    do_reset();
    step(666, 140, 1'b0, 1'b1, 1'b1, z,  1'b1);
    step(954, 140, 1'b0, 1'b1, 1'b1, z,  1'b1);
    step(1,   1,   1'b0, 1'b0, 1'b0, z,  1'b0);
    step(1,   1,   1'b0, 1'b0, 1'b0, z,  1'b0);
    step(1,   1,   1'b0, 1'b0, 1'b0, z,  1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
